multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the MiniRiscV core, and the initiator side of the `ALU` control interface.
- Owns the PC and instruction register, and decodes each instruction into `ALUOp`/`ALUSrc`/`funct3`/`funct7` for the ALU.
- Consumes `ALUResult`/`doBranch`/`jmp` to sequence memory access, register writeback and the PC update.
- Runs FETCH → DECODE → EXECUTE → (MEM) → WRITEBACK, with req/ready handshakes to instruction and data memory.

---
 rtl/multicycle_ctrl_if.sv | 27 ++
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory request/ready buses driven by the multicycle control sequencer.
// master = sequencer side, slave = memory side.
interface multicycle_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the MiniRiscV core.
// Owns pc and ir, decodes ALU controls, and sequences memory, writeback and pc update.
module multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus,
   output logic [31:0]       ir,
   input  logic [31:0]       rs1_data,
   input  logic [31:0]       rs2_data,
   input  logic [31:0]       imm32,
   output logic [3:0]        ALUOp,
   output logic [1:0]        ALUSrc,
   output logic [2:0]        funct3,
   output logic [6:0]        funct7,
   input  logic [31:0]       ALUResult,
   input  logic              doBranch,
   input  logic              jmp,
   output logic              reg_we,
   output logic              reg_wsel,
   output logic [31:0]       pc,
   output logic              retired,
   output logic              halted
);
   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   state_t      state_r, next_state_s;
   logic [31:0] pc_r, ir_r, alu_q_r, wdata_q_r, target_r, target_s;
   logic [3:0]  aluop_r, dec_op_s;
   logic [1:0]  alusrc_r, dec_src_s;
   logic [2:0]  funct3_r;
   logic [6:0]  funct7_r;
   logic        is_store_r, is_mem_r, wr_en_r, wsel_r;
   logic        dec_zero_fn_s, dec_load_s, dec_store_s, dec_wr_s, dec_illegal_s;
   logic        imem_req_r, dmem_req_r, dmem_we_r, reg_we_r, retired_r, halted_r;

   // Opcode decode of the latched instruction word.
   always_comb begin
      dec_op_s      = 4'd0;
      dec_src_s     = 2'b00;
      dec_zero_fn_s = 1'b0;
      dec_load_s    = 1'b0;
      dec_store_s   = 1'b0;
      dec_wr_s      = 1'b1;
      dec_illegal_s = 1'b0;
      case (ir_r[6:0])
         7'h33: dec_illegal_s = (ir_r[14:13] == 2'b01);
         7'h13: begin dec_op_s = 4'd1; dec_src_s = 2'b10; dec_illegal_s = (ir_r[14:13] == 2'b01); end
         7'h03: begin dec_op_s = 4'd2; dec_src_s = 2'b10; dec_load_s = 1'b1; end
         7'h23: begin dec_op_s = 4'd2; dec_src_s = 2'b10; dec_store_s = 1'b1; dec_wr_s = 1'b0; end
         7'h63: begin dec_op_s = 4'd3; dec_wr_s = 1'b0; end
         7'h6F: begin dec_op_s = 4'd4; dec_src_s = 2'b01; end
         7'h67: begin dec_op_s = 4'd5; dec_src_s = 2'b01; end
         7'h37: begin dec_op_s = 4'd6; dec_src_s = 2'b10; end
         7'h17: begin dec_op_s = 4'd1; dec_src_s = 2'b11; dec_zero_fn_s = 1'b1; end
         default: begin dec_wr_s = 1'b0; dec_illegal_s = 1'b1; end
      endcase
   end

   // Next-pc selection; jalr takes priority over a taken branch.
   always_comb begin
      if (jmp) begin
         target_s = (rs1_data + imm32) & ~32'd1;
      end else if (doBranch) begin
         target_s = pc_r + imm32;
      end else begin
         target_s = pc_r + 32'd4;
      end
   end

   // Next-state logic; ready is only honoured while the matching request is up.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_FETCH:   next_state_s = (imem_req_r && bus.imem_ready) ? S_DECODE : S_FETCH;
         S_DECODE:  next_state_s = dec_illegal_s ? S_HALT : S_EXECUTE;
         S_EXECUTE: next_state_s = is_mem_r ? S_MEM : S_WB;
         S_MEM:     next_state_s = (dmem_req_r && bus.dmem_ready) ? S_WB : S_MEM;
         S_WB:      next_state_s = S_FETCH;
         S_HALT:    next_state_s = S_HALT;
         default:   next_state_s = S_HALT;
      endcase
   end

   // State register and handshake/strobe outputs, registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= S_FETCH;
         imem_req_r <= 1'b0;
         dmem_req_r <= 1'b0;
         dmem_we_r  <= 1'b0;
         reg_we_r   <= 1'b0;
         retired_r  <= 1'b0;
         halted_r   <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         imem_req_r <= (next_state_s == S_FETCH);
         dmem_req_r <= (next_state_s == S_MEM);
         dmem_we_r  <= (next_state_s == S_MEM) && is_store_r;
         reg_we_r   <= (next_state_s == S_WB) && wr_en_r;
         retired_r  <= (next_state_s == S_WB);
         halted_r   <= (next_state_s == S_HALT);
      end
   end

   // Datapath registers: ir, decoded fields, execute results and pc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r       <= RESET_PC;
         ir_r       <= 32'd0;
         aluop_r    <= 4'd0;
         alusrc_r   <= 2'b00;
         funct3_r   <= 3'd0;
         funct7_r   <= 7'd0;
         is_store_r <= 1'b0;
         is_mem_r   <= 1'b0;
         wr_en_r    <= 1'b0;
         wsel_r     <= 1'b0;
         alu_q_r    <= 32'd0;
         wdata_q_r  <= 32'd0;
         target_r   <= 32'd0;
      end else begin
         if ((state_r == S_FETCH) && (next_state_s == S_DECODE)) begin
            ir_r <= bus.imem_rdata;
         end
         if (state_r == S_DECODE) begin
            aluop_r    <= dec_op_s;
            alusrc_r   <= dec_src_s;
            funct3_r   <= dec_zero_fn_s ? 3'd0 : ir_r[14:12];
            funct7_r   <= dec_zero_fn_s ? 7'd0 : ir_r[31:25];
            is_store_r <= dec_store_s;
            is_mem_r   <= dec_load_s || dec_store_s;
            wr_en_r    <= dec_wr_s;
            wsel_r     <= dec_load_s;
         end
         if (state_r == S_EXECUTE) begin
            alu_q_r   <= ALUResult;
            wdata_q_r <= rs2_data;
            target_r  <= target_s;
         end
         if (state_r == S_WB) begin
            pc_r <= target_r;
         end
      end
   end

   assign bus.imem_req   = imem_req_r;
   assign bus.imem_addr  = pc_r;
   assign bus.dmem_req   = dmem_req_r;
   assign bus.dmem_we    = dmem_we_r;
   assign bus.dmem_addr  = alu_q_r;
   assign bus.dmem_wdata = wdata_q_r;
   assign ir       = ir_r;
   assign ALUOp    = aluop_r;
   assign ALUSrc   = alusrc_r;
   assign funct3   = funct3_r;
   assign funct7   = funct7_r;
   assign reg_we   = reg_we_r;
   assign reg_wsel = wsel_r;
   assign pc       = pc_r;
   assign retired  = retired_r;
   assign halted   = halted_r;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised self-checking bench for multicycle_ctrl; the bench plays memory, regfile and ALU,
// and predicts behaviour from an opcode table plus plain pc arithmetic.
module tb_multicycle_ctrl;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ir, rs1_data, rs2_data, imm32, ALUResult, pc;
   logic [3:0]  ALUOp;
   logic [1:0]  ALUSrc;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        doBranch, jmp, reg_we, reg_wsel, retired, halted;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .bus(bus), .ir(ir),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm32(imm32),
      .ALUOp(ALUOp), .ALUSrc(ALUSrc), .funct3(funct3), .funct7(funct7),
      .ALUResult(ALUResult), .doBranch(doBranch), .jmp(jmp),
      .reg_we(reg_we), .reg_wsel(reg_wsel), .pc(pc), .retired(retired), .halted(halted)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int chks = 0;

   // expected behaviour per opcode
   typedef struct packed {
      logic       legal;
      logic [3:0] op;
      logic [1:0] src;
      logic       zfn;
      logic       mem;
      logic       st;
      logic       wr;
      logic       ld;
   } dec_t;
   dec_t tab [128];

   logic [31:0] m_pc;

   int          o_req_start, o_lat, o_we_n, o_we_cyc, o_dreq_n, o_ret_n, o_ireq_n, o_halt_cyc;
   logic        o_wsel, o_dstable, o_dwe, o_rst_dreq, o_rst_ireq;
   logic [3:0]  o_op;
   logic [1:0]  o_src;
   logic [2:0]  o_f3;
   logic [6:0]  o_f7;
   logic [31:0] o_daddr, o_dwdata, o_iaddr, o_pc_after, o_rst_pc;

   task automatic init_tab();
      for (int i = 0; i < 128; i++) tab[i] = '0;
      tab[7'h33] = {1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tab[7'h13] = {1'b1, 4'd1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tab[7'h03] = {1'b1, 4'd2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tab[7'h23] = {1'b1, 4'd2, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tab[7'h63] = {1'b1, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tab[7'h6F] = {1'b1, 4'd4, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tab[7'h67] = {1'b1, 4'd5, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tab[7'h37] = {1'b1, 4'd6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tab[7'h17] = {1'b1, 4'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   endtask

   function automatic logic [31:0] model_target(input logic [31:0] cur, r1, im, input logic br, jp);
      if (jp) return (r1 + im) & 32'hFFFF_FFFE;
      if (br) return cur + im;
      return cur + 32'd4;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = 32'd0;
      doBranch = 1'b0; jmp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pc = RPC;
   endtask

   // Plays one instruction through the DUT cycle by cycle and records what it saw.
   task automatic run_instr(input logic [31:0] ins, r1, r2, im, al, input logic br, jp,
                            input int iw0, dw0, maxc, rst_at);
      int cyc, fdone, iw, dw;
      logic done;
      cyc = 0; fdone = -100; iw = iw0; dw = dw0; done = 1'b0;
      o_req_start = -1; o_lat = -1; o_we_n = 0; o_we_cyc = -1; o_dreq_n = 0; o_ret_n = 0;
      o_ireq_n = 0; o_halt_cyc = -1; o_wsel = 1'bx; o_dstable = 1'b1; o_dwe = 1'bx;
      o_op = 'x; o_src = 'x; o_f3 = 'x; o_f7 = 'x; o_daddr = 'x; o_dwdata = 'x; o_iaddr = 'x;
      rs1_data = r1; rs2_data = r2; imm32 = im; ALUResult = al;
      while (!done && cyc < maxc) begin
         @(negedge clk);
         cyc++;
         if (halted === 1'b1 && o_halt_cyc < 0 && o_req_start >= 0) o_halt_cyc = cyc - o_req_start + 1;
         if (bus.imem_req === 1'b1) begin
            o_ireq_n++;
            if (o_req_start < 0) begin o_req_start = cyc; o_iaddr = bus.imem_addr; end
            if (iw == 0) begin
               bus.imem_ready = 1'b1; bus.imem_rdata = ins; fdone = cyc;
            end else begin
               iw--; bus.imem_ready = 1'b0; bus.imem_rdata = $urandom;
            end
         end else begin
            bus.imem_ready = 1'($urandom_range(1, 0)); bus.imem_rdata = $urandom;
         end
         if (cyc == fdone + 2) begin
            doBranch = br; jmp = jp;
            o_op = ALUOp; o_src = ALUSrc; o_f3 = funct3; o_f7 = funct7;
         end else begin
            doBranch = 1'($urandom_range(1, 0)); jmp = 1'($urandom_range(1, 0));
         end
         if (bus.dmem_req === 1'b1) begin
            if (o_dreq_n == 0) begin
               o_daddr = bus.dmem_addr; o_dwdata = bus.dmem_wdata; o_dwe = bus.dmem_we;
            end else if (bus.dmem_addr !== o_daddr || bus.dmem_wdata !== o_dwdata || bus.dmem_we !== o_dwe) begin
               o_dstable = 1'b0;
            end
            o_dreq_n++;
            if (rst_at > 0 && o_dreq_n == rst_at) begin
               #2 rst = 1'b1;
               #1 o_rst_dreq = bus.dmem_req; o_rst_ireq = bus.imem_req; o_rst_pc = pc;
               bus.dmem_ready = 1'b0; bus.imem_ready = 1'b0;
               done = 1'b1;
            end else if (dw == 0) begin
               bus.dmem_ready = 1'b1;
            end else begin
               dw--; bus.dmem_ready = 1'b0;
            end
         end else begin
            bus.dmem_ready = 1'($urandom_range(1, 0));
         end
         if (reg_we === 1'b1) begin o_we_n++; o_wsel = reg_wsel; o_we_cyc = cyc - o_req_start + 1; end
         if (retired === 1'b1) begin o_ret_n++; o_lat = cyc - o_req_start + 1; done = 1'b1; end
      end
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; doBranch = 1'b0; jmp = 1'b0;
      if (rst_at == 0) begin
         @(posedge clk); #1;
         o_pc_after = pc;
      end
   endtask

   task automatic filler();
      run_instr(32'h0000_0033, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0, 0, 0, 40, 0);
      m_pc = m_pc + 32'd4;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.imem_rdata = 32'd0;
      doBranch = 1'b0; jmp = 1'b0; rs1_data = 32'd0; rs2_data = 32'd0; imm32 = 32'd0; ALUResult = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chks++; if (pc !== RPC) begin errs++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
      chks++; if ({ir, ALUOp, ALUSrc, funct3, funct7} !== 48'd0) begin errs++; $display("FAIL rst_fields: got %h want 0", {ir, ALUOp, ALUSrc, funct3, funct7}); end
      chks++; if ({bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we, retired, halted} !== 6'd0) begin errs++; $display("FAIL rst_strobes: got %b want 000000", {bus.imem_req, bus.dmem_req, bus.dmem_we, reg_we, retired, halted}); end
      chks++; if (bus.dmem_addr !== 32'd0) begin errs++; $display("FAIL rst_alu_q: got %h want 0", bus.dmem_addr); end
      @(negedge clk); rst = 1'b0; #1;
      chks++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_req_early: got %b want 0", bus.imem_req); end
      @(posedge clk); #1;
      chks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errs++; $display("FAIL rst_first_req: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RPC); end
      m_pc = RPC;
   endtask

   task automatic test_addi();
      run_instr(32'h0050_0093, $urandom, $urandom, 32'd5, 32'd5, 1'b0, 1'b0, 0, 0, 40, 0);
      chks++; if (o_iaddr !== m_pc) begin errs++; $display("FAIL addi_iaddr: got %h want %h", o_iaddr, m_pc); end
      chks++; if (o_op !== 4'd1 || o_src !== 2'b10) begin errs++; $display("FAIL addi_dec: got %0d/%b want 1/10", o_op, o_src); end
      chks++; if (o_f3 !== 3'd0 || o_f7 !== 7'd0) begin errs++; $display("FAIL addi_funct: got %0d/%0d want 0/0", o_f3, o_f7); end
      chks++; if (o_we_n !== 1 || o_we_cyc !== 4 || o_wsel !== 1'b0) begin errs++; $display("FAIL addi_we: got n=%0d cyc=%0d sel=%b want 1/4/0", o_we_n, o_we_cyc, o_wsel); end
      chks++; if (o_ret_n !== 1 || o_lat !== 4) begin errs++; $display("FAIL addi_retire: got n=%0d lat=%0d want 1/4", o_ret_n, o_lat); end
      chks++; if (o_pc_after !== m_pc + 32'd4) begin errs++; $display("FAIL addi_pc: got %h want %h", o_pc_after, m_pc + 32'd4); end
      m_pc = m_pc + 32'd4;
   endtask

   task automatic test_branch();
      logic [31:0] beq;
      beq = 32'hFE20_8CE3;
      for (int t = 0; t < 2; t++) begin
         for (int k = 0; k < 8 && m_pc != 32'h10; k++) filler();
         run_instr(beq, $urandom, $urandom, 32'hFFFF_FFF8, $urandom, (t == 0), 1'b0, 1, 0, 40, 0);
         chks++; if (o_iaddr !== 32'h10) begin errs++; $display("FAIL br%0d_iaddr: got %h want 10", t, o_iaddr); end
         chks++; if (o_op !== 4'd3 || o_src !== 2'b00 || o_f7 !== beq[31:25]) begin errs++; $display("FAIL br%0d_dec: got %0d/%b/%h want 3/00/%h", t, o_op, o_src, o_f7, beq[31:25]); end
         chks++; if (o_we_n !== 0 || o_ret_n !== 1 || o_lat !== 5) begin errs++; $display("FAIL br%0d_seq: got we=%0d ret=%0d lat=%0d want 0/1/5", t, o_we_n, o_ret_n, o_lat); end
         chks++; if (o_pc_after !== ((t == 0) ? 32'h08 : 32'h14)) begin errs++; $display("FAIL br%0d_pc: got %h want %h", t, o_pc_after, (t == 0) ? 32'h08 : 32'h14); end
         m_pc = (t == 0) ? 32'h08 : 32'h14;
      end
   endtask

   task automatic test_jalr();
      logic [31:0] link;
      link = m_pc + 32'd4;
      run_instr(32'h0040_80E7, 32'h0000_0103, $urandom, 32'd4, link, 1'b0, 1'b1, 0, 0, 40, 0);
      chks++; if (o_op !== 4'd5 || o_src !== 2'b01) begin errs++; $display("FAIL jalr_dec: got %0d/%b want 5/01", o_op, o_src); end
      chks++; if (o_we_n !== 1 || o_wsel !== 1'b0 || o_lat !== 4) begin errs++; $display("FAIL jalr_we: got n=%0d sel=%b lat=%0d want 1/0/4", o_we_n, o_wsel, o_lat); end
      chks++; if (o_pc_after !== 32'h0000_0106) begin errs++; $display("FAIL jalr_pc: got %h want 106", o_pc_after); end
      m_pc = 32'h0000_0106;
   endtask

   task automatic test_store_load();
      run_instr(32'h0020_A223, $urandom, 32'hDEAD_BEEF, 32'd4, 32'h0000_1234, 1'b0, 1'b0, 0, 3, 40, 0);
      chks++; if (o_dreq_n !== 4 || o_dstable !== 1'b1) begin errs++; $display("FAIL st_req: got n=%0d stable=%b want 4/1", o_dreq_n, o_dstable); end
      chks++; if (o_dwe !== 1'b1 || o_daddr !== 32'h1234 || o_dwdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL st_bus: got we=%b a=%h d=%h want 1/1234/deadbeef", o_dwe, o_daddr, o_dwdata); end
      chks++; if (o_lat !== 8 || o_we_n !== 0 || o_op !== 4'd2 || o_src !== 2'b10) begin errs++; $display("FAIL st_seq: got lat=%0d we=%0d op=%0d src=%b want 8/0/2/10", o_lat, o_we_n, o_op, o_src); end
      chks++; if (o_pc_after !== m_pc + 32'd4) begin errs++; $display("FAIL st_pc: got %h want %h", o_pc_after, m_pc + 32'd4); end
      m_pc = m_pc + 32'd4;
      run_instr(32'h0040_A183, $urandom, 32'h5555_AAAA, 32'd4, 32'h0000_0040, 1'b0, 1'b0, 0, 1, 40, 0);
      chks++; if (o_dreq_n !== 2 || o_dwe !== 1'b0 || o_daddr !== 32'h40) begin errs++; $display("FAIL ld_bus: got n=%0d we=%b a=%h want 2/0/40", o_dreq_n, o_dwe, o_daddr); end
      chks++; if (o_we_n !== 1 || o_wsel !== 1'b1 || o_lat !== 6) begin errs++; $display("FAIL ld_we: got n=%0d sel=%b lat=%0d want 1/1/6", o_we_n, o_wsel, o_lat); end
      m_pc = m_pc + 32'd4;
   endtask

   task automatic test_random();
      logic [6:0] ops [9];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ins, r1, r2, im, al, exp_pc;
         logic        br, jp;
         logic [2:0]  ef3;
         logic [6:0]  ef7;
         int          iw, dw, exp_lat;
         dec_t        d;
         ins = $urandom; ins[6:0] = ops[$urandom_range(8, 0)];
         if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && ins[14:13] == 2'b01) ins[14] = 1'b1;
         r1 = $urandom; r2 = $urandom; im = $urandom; al = $urandom;
         br = 1'($urandom_range(1, 0)); jp = 1'($urandom_range(1, 0));
         iw = $urandom_range(3, 0); dw = $urandom_range(3, 0);
         d = tab[ins[6:0]];
         ef3 = d.zfn ? 3'd0 : ins[14:12];
         ef7 = d.zfn ? 7'd0 : ins[31:25];
         exp_pc = model_target(m_pc, r1, im, br, jp);
         exp_lat = 4 + iw + (d.mem ? 1 + dw : 0);
         run_instr(ins, r1, r2, im, al, br, jp, iw, dw, 60, 0);
         chks++; if (o_iaddr !== m_pc) begin errs++; $display("FAIL rnd%0d_iaddr: got %h want %h", n, o_iaddr, m_pc); end
         chks++; if (o_op !== d.op || o_src !== d.src) begin errs++; $display("FAIL rnd%0d_dec ins=%h: got %0d/%b want %0d/%b", n, ins, o_op, o_src, d.op, d.src); end
         chks++; if (o_f3 !== ef3 || o_f7 !== ef7) begin errs++; $display("FAIL rnd%0d_funct ins=%h: got %0d/%h want %0d/%h", n, ins, o_f3, o_f7, ef3, ef7); end
         chks++; if (o_ret_n !== 1 || o_lat !== exp_lat) begin errs++; $display("FAIL rnd%0d_lat ins=%h: got n=%0d lat=%0d want 1/%0d", n, ins, o_ret_n, o_lat, exp_lat); end
         chks++; if (o_we_n !== (d.wr ? 1 : 0)) begin errs++; $display("FAIL rnd%0d_we ins=%h: got %0d want %0d", n, ins, o_we_n, d.wr ? 1 : 0); end
         if (d.wr) begin
            chks++; if (o_wsel !== d.ld || o_we_cyc !== exp_lat) begin errs++; $display("FAIL rnd%0d_wsel: got %b@%0d want %b@%0d", n, o_wsel, o_we_cyc, d.ld, exp_lat); end
         end
         chks++; if (o_dreq_n !== (d.mem ? dw + 1 : 0)) begin errs++; $display("FAIL rnd%0d_dreq: got %0d want %0d", n, o_dreq_n, d.mem ? dw + 1 : 0); end
         if (d.mem) begin
            chks++; if (o_daddr !== al || o_dwdata !== r2 || o_dwe !== d.st || o_dstable !== 1'b1) begin errs++; $display("FAIL rnd%0d_dbus: got %h/%h/%b/%b want %h/%h/%b/1", n, o_daddr, o_dwdata, o_dwe, o_dstable, al, r2, d.st); end
         end
         chks++; if (o_pc_after !== exp_pc) begin errs++; $display("FAIL rnd%0d_pc ins=%h: got %h want %h", n, ins, o_pc_after, exp_pc); end
         m_pc = exp_pc;
      end
   endtask

   task automatic test_reset_mid_mem();
      for (int k = 0; k < 4 && m_pc == RPC; k++) filler();
      run_instr(32'h0040_A183, $urandom, $urandom, 32'd4, 32'h0000_0080, 1'b0, 1'b0, 0, 5, 40, 2);
      chks++; if (o_rst_dreq !== 1'b0 || o_rst_ireq !== 1'b0) begin errs++; $display("FAIL rmm_drop: got d=%b i=%b want 0/0", o_rst_dreq, o_rst_ireq); end
      chks++; if (o_rst_pc !== RPC) begin errs++; $display("FAIL rmm_pc: got %h want %h", o_rst_pc, RPC); end
      @(negedge clk); rst = 1'b0; #1;
      chks++; if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin errs++; $display("FAIL rmm_quiet: got i=%b d=%b want 0/0", bus.imem_req, bus.dmem_req); end
      @(posedge clk); #1;
      chks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errs++; $display("FAIL rmm_refetch: got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, RPC); end
      m_pc = RPC;
      run_instr(32'h0050_0093, $urandom, $urandom, 32'd5, 32'd5, 1'b0, 1'b0, 0, 0, 40, 0);
      chks++; if (o_iaddr !== RPC || o_lat !== 4 || o_pc_after !== RPC + 32'd4) begin errs++; $display("FAIL rmm_after: got a=%h lat=%0d pc=%h want %h/4/%h", o_iaddr, o_lat, o_pc_after, RPC, RPC + 32'd4); end
      m_pc = RPC + 32'd4;
   endtask

   task automatic test_illegal();
      logic [31:0] bad [4];
      bad = '{32'h0000_0073, 32'h0020_A013, 32'h0000_3033, 32'h0000_007F};
      for (int k = 0; k < 4; k++) begin
         do_reset();
         run_instr(bad[k], $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b1, 0, 0, 25, 0);
         chks++; if (o_ret_n !== 0 || o_we_n !== 0 || o_dreq_n !== 0) begin errs++; $display("FAIL ill%0d_quiet: got ret=%0d we=%0d dreq=%0d want 0/0/0", k, o_ret_n, o_we_n, o_dreq_n); end
         chks++; if (o_ireq_n !== 1) begin errs++; $display("FAIL ill%0d_ireq: got %0d req cycles want 1", k, o_ireq_n); end
         chks++; if (o_halt_cyc !== 3 || halted !== 1'b1) begin errs++; $display("FAIL ill%0d_halt: got cyc=%0d h=%b want 3/1", k, o_halt_cyc, halted); end
         chks++; if (o_pc_after !== RPC) begin errs++; $display("FAIL ill%0d_pc: got %h want %h", k, o_pc_after, RPC); end
      end
   endtask

   initial begin
      init_tab();
      test_reset();
      test_addi();
      test_branch();
      test_jalr();
      test_store_load();
      test_random();
      test_reset_mid_mem();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, chks);
      $fatal(1);
   end
endmodule
